// File: rtl/msg_pkg.sv
// Shared widths, FSM state type and display constants for the ROM message scanner.
package msg_pkg;

    localparam int unsigned ADDR_W = 10;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned SEG_W  = 7;

    typedef enum logic [1:0] {
        StIdle,
        StFetch,
        StCapture,
        StShow
    } state_e;

    localparam logic [SEG_W-1:0] SEG_BLANK = 7'h00;
    localparam logic [1:0]       DIG_OFF   = 2'b11;
    localparam logic [1:0]       DIG_LEFT  = 2'b01;
    localparam logic [1:0]       DIG_RIGHT = 2'b10;

endpackage

// File: rtl/seg_scan_mux.sv
// Two-digit 7-segment multiplexer: scan counter, phase toggle and registered seg/dig_sel.
module seg_scan_mux
    import msg_pkg::*;
#(
    parameter int unsigned SCAN_DIV = 25_000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             active,
    input  logic [13:0]      word,
    output logic [SEG_W-1:0] seg,
    output logic [1:0]       dig_sel
);

    localparam int unsigned        CNT_W   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             phase_q, phase_d;
    logic [SEG_W-1:0] seg_q, seg_d;
    logic [1:0]       dig_q, dig_d;

    always_comb begin
        cnt_d   = cnt_q;
        phase_d = phase_q;
        seg_d   = SEG_BLANK;
        dig_d   = DIG_OFF;
        if (!active) begin
            cnt_d   = '0;
            phase_d = 1'b0;
        end else begin
            // Coming out of blank always starts on the left digit with a fresh count.
            if (dig_q == DIG_OFF) begin
                cnt_d   = '0;
                phase_d = 1'b0;
            end else if (cnt_q == CNT_LAST) begin
                cnt_d   = '0;
                phase_d = ~phase_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
            seg_d = phase_d ? word[6:0] : word[13:7];
            dig_d = phase_d ? DIG_RIGHT : DIG_LEFT;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            phase_q <= 1'b0;
            seg_q   <= SEG_BLANK;
            dig_q   <= DIG_OFF;
        end else begin
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
            seg_q   <= seg_d;
            dig_q   <= dig_d;
        end
    end

    assign seg     = seg_q;
    assign dig_sel = dig_q;

endmodule

// File: rtl/rom_msg_scanner.sv
// Walks a message stored in ROM: fetches one word per dwell period and shows its two
// characters on a multiplexed 2-digit 7-segment display.
module rom_msg_scanner
    import msg_pkg::*;
#(
    parameter int unsigned       MSG_LEN   = 6,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
    parameter int unsigned       STEP_DIV  = 50_000_000,
    parameter int unsigned       SCAN_DIV  = 25_000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    output logic [ADDR_W-1:0] address,
    output logic              cs_rom,
    input  logic [DATA_W-1:0] rom_data,
    output logic [SEG_W-1:0]  seg,
    output logic [1:0]        dig_sel,
    output logic              wrap
);

    localparam int unsigned      IDX_W    = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(MSG_LEN - 1);
    localparam int unsigned      DW_W     = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam logic [DW_W-1:0]  DW_LAST  = DW_W'(STEP_DIV - 1);

    state_e            state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [ADDR_W-1:0] address_q, address_d;
    logic [DW_W-1:0]   dwell_q, dwell_d;
    logic              wrap_q, wrap_d;
    logic [13:0]       disp_q, disp_d;
    logic              disp_valid_q, disp_valid_d;

    logic              scan_active;
    logic [13:0]       scan_word;

    // Character bits only; the top two ROM bits carry no display meaning.
    logic              unused_rom_bits;
    assign unused_rom_bits = ^rom_data[15:14];

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        address_d    = address_q;
        dwell_d      = dwell_q;
        wrap_d       = 1'b0;
        disp_d       = disp_q;
        disp_valid_d = disp_valid_q;
        if (state_q != StIdle && !en) begin
            state_d      = StIdle;
            idx_d        = '0;
            address_d    = BASE_ADDR;
            dwell_d      = '0;
            disp_valid_d = 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (en) state_d = StFetch;
                end
                StFetch: state_d = StCapture;
                StCapture: begin
                    disp_d       = rom_data[13:0];
                    disp_valid_d = 1'b1;
                    dwell_d      = '0;
                    state_d      = StShow;
                end
                StShow: begin
                    if (dwell_q == DW_LAST) begin
                        idx_d     = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
                        address_d = BASE_ADDR + ADDR_W'(idx_d);
                        wrap_d    = (idx_d == '0);
                        dwell_d   = '0;
                        state_d   = StFetch;
                    end else begin
                        dwell_d = dwell_q + DW_W'(1);
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            idx_q        <= '0;
            address_q    <= BASE_ADDR;
            dwell_q      <= '0;
            wrap_q       <= 1'b0;
            disp_q       <= '0;
            disp_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            address_q    <= address_d;
            dwell_q      <= dwell_d;
            wrap_q       <= wrap_d;
            disp_q       <= disp_d;
            disp_valid_q <= disp_valid_d;
        end
    end

    // Feed the fresh ROM word straight in during CAPTURE so it shows on the load edge.
    assign scan_active = en && ((state_q == StCapture) || (state_q != StIdle && disp_valid_q));
    assign scan_word   = (state_q == StCapture) ? rom_data[13:0] : disp_q;

    seg_scan_mux #(
        .SCAN_DIV (SCAN_DIV)
    ) u_seg_scan_mux (
        .clk     (clk),
        .rst_n   (rst_n),
        .active  (scan_active),
        .word    (scan_word),
        .seg     (seg),
        .dig_sel (dig_sel)
    );

    assign address = address_q;
    assign cs_rom  = (state_q == StFetch);
    assign wrap    = wrap_q;

endmodule

// File: tb/tb_rom_msg_scanner.sv
// Bench for rom_msg_scanner: three parameterisations share clock, reset and enable and are
// compared every cycle against a timeline model derived from cycles since enable.
module tb_rom_msg_scanner;

    logic clk;
    logic rst_n;
    logic en;

    logic [2:0][9:0]  addr;
    logic [2:0]       cs;
    logic [2:0][15:0] rdata;
    logic [2:0][6:0]  seg;
    logic [2:0][1:0]  dig;
    logic [2:0]       wrap;

    logic [15:0] rom [1024];

    int unsigned n_cmp;
    int unsigned n_err;

    // Model state: cycles since the edge that started the current run.
    bit          running;
    int unsigned run_t;

    function automatic int unsigned par_len(int i);
        case (i)
            0: return 6;
            1: return 4;
            default: return 1;
        endcase
    endfunction

    function automatic int unsigned par_base(int i);
        case (i)
            0: return 0;
            1: return 'h3FE;
            default: return 2;
        endcase
    endfunction

    function automatic int unsigned par_step(int i);
        case (i)
            0: return 8;
            1: return 8;
            default: return 1;
        endcase
    endfunction

    function automatic int unsigned par_scan(int i);
        case (i)
            0: return 2;
            1: return 2;
            default: return 3;
        endcase
    endfunction

    rom_msg_scanner #(.MSG_LEN(6), .BASE_ADDR(10'h000), .STEP_DIV(8), .SCAN_DIV(2)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .en(en), .address(addr[0]), .cs_rom(cs[0]),
        .rom_data(rdata[0]), .seg(seg[0]), .dig_sel(dig[0]), .wrap(wrap[0])
    );
    rom_msg_scanner #(.MSG_LEN(4), .BASE_ADDR(10'h3FE), .STEP_DIV(8), .SCAN_DIV(2)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .en(en), .address(addr[1]), .cs_rom(cs[1]),
        .rom_data(rdata[1]), .seg(seg[1]), .dig_sel(dig[1]), .wrap(wrap[1])
    );
    rom_msg_scanner #(.MSG_LEN(1), .BASE_ADDR(10'h002), .STEP_DIV(1), .SCAN_DIV(3)) u_dut_c (
        .clk(clk), .rst_n(rst_n), .en(en), .address(addr[2]), .cs_rom(cs[2]),
        .rom_data(rdata[2]), .seg(seg[2]), .dig_sel(dig[2]), .wrap(wrap[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ROM with one-cycle registered read.
    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (cs[i]) rdata[i] <= rom[addr[i]];
        end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            running <= 1'b0;
            run_t   <= 0;
        end else if (!en) begin
            running <= 1'b0;
            run_t   <= 0;
        end else if (!running) begin
            running <= 1'b1;
            run_t   <= 0;
        end else begin
            run_t <= run_t + 1;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            automatic int unsigned p, w, pos, wd, ph, len, base;
            automatic logic [15:0] word;
            automatic logic [31:0] e_addr, e_cs, e_wrap, e_seg, e_dig;
            len    = par_len(i);
            base   = par_base(i);
            e_addr = base;
            e_cs   = 0;
            e_wrap = 0;
            e_seg  = 0;
            e_dig  = 3;
            if (running) begin
                p      = par_step(i) + 2;
                w      = run_t / p;
                pos    = run_t % p;
                e_addr = (base + w % len) % 1024;
                e_cs   = (pos == 0) ? 1 : 0;
                e_wrap = (w > 0 && pos == 0 && (w % len) == 0) ? 1 : 0;
                if (run_t >= 2) begin
                    wd    = (run_t - 2) / p;
                    word  = rom[(base + wd % len) % 1024];
                    ph    = ((run_t - 2) / par_scan(i)) % 2;
                    e_seg = (ph == 0) ? 32'(word[13:7]) : 32'(word[6:0]);
                    e_dig = (ph == 0) ? 1 : 2;
                end
            end
            check_eq($sformatf("address[%0d]", i), 32'(addr[i]), e_addr);
            check_eq($sformatf("cs_rom[%0d]", i), 32'(cs[i]), e_cs);
            check_eq($sformatf("wrap[%0d]", i), 32'(wrap[i]), e_wrap);
            check_eq($sformatf("seg[%0d]", i), 32'(seg[i]), e_seg);
            check_eq($sformatf("dig_sel[%0d]", i), 32'(dig[i]), e_dig);
        end
    end

    task automatic cycles(input int unsigned n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    initial begin
        automatic bit found = 1'b0;
        n_cmp = 0;
        n_err = 0;
        en    = 1'b0;
        rst_n = 1'b0;
        for (int a = 0; a < 1024; a++) rom[a] = 16'($urandom);
        rom[0] = 16'h034F;
        rom[1] = 16'h0366;
        rom[2] = 16'h1C3F;
        rom[3] = 16'h1F79;
        rom[4] = 16'h006E;
        rom[5] = 16'h1FBE;

        cycles(3);
        rst_n = 1'b1;
        cycles(2);

        // Full cycle through all words, then drop and restore enable.
        en = 1'b1;
        cycles(75);
        en = 1'b0;
        cycles(3);
        en = 1'b1;
        cycles(35);

        for (int k = 0; k < 20; k++) begin
            en = 1'b1;
            cycles($urandom_range(3, 60));
            if ($urandom_range(0, 3) == 0) begin
                #1 rst_n = 1'b0;
                cycles(2);
                rst_n = 1'b1;
            end else begin
                en = 1'b0;
                cycles($urandom_range(1, 3));
            end
        end

        // Asynchronous reset landing inside a CAPTURE cycle of the first instance.
        en = 1'b1;
        cycles(1);
        for (int g = 0; g < 40 && !found; g++) begin
            if (running && (run_t % 10) == 1) found = 1'b1;
            else cycles(1);
        end
        check_eq("capture_seek", 32'(found), 32'd1);
        if (found) begin
            #1 rst_n = 1'b0;
            cycles(1);
            rst_n = 1'b1;
            en    = 1'b0;
            cycles(3);
            en = 1'b1;
            cycles(30);
        end
        en = 1'b0;
        cycles(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
